icache_fill_unit: RTL

Line-fill engine that sits directly upstream of the icache write port. It accepts one miss address at a time from the icache management unit and issues a single line request on the memory bus. It collects the 16 returned 32-bit words, which may arrive in any order, into a line buffer, then streams them into the icache 4 bytes per cycle and finishes by writing the tag and metadata. One fill is in flight at a time; `miss_ready` provides backpressure.

---
 rtl/icache_fill_if.sv | 42 ++++
 rtl/icache_fill_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/icache_fill_if.sv
// Bus bundle between the icache fill unit, the miss source, the memory bus and the icache write port.
interface icache_fill_if;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [2:0]  mem_req_id;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [2:0]  mem_resp_id;
  logic [3:0]  mem_resp_word;
  logic [31:0] mem_resp_data;
  logic        icache_enable;
  logic        write_enable;
  logic [31:0] VA_to_access;
  logic [31:0] write_data;
  logic [23:0] physical_tag;
  logic        tag_write_enable;
  logic        valid_data;
  logic        dirty_data;
  logic        fill_done;
  logic [31:0] fill_addr;

  // master = the fill unit, slave = its surroundings
  modport master (
    input  miss_valid, miss_addr, flush, mem_req_ready,
           mem_resp_valid, mem_resp_id, mem_resp_word, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr, mem_req_id,
           icache_enable, write_enable, VA_to_access, write_data, physical_tag,
           tag_write_enable, valid_data, dirty_data, fill_done, fill_addr
  );

  modport slave (
    output miss_valid, miss_addr, flush, mem_req_ready,
           mem_resp_valid, mem_resp_id, mem_resp_word, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr, mem_req_id,
           icache_enable, write_enable, VA_to_access, write_data, physical_tag,
           tag_write_enable, valid_data, dirty_data, fill_done, fill_addr
  );
endinterface

// File: rtl/icache_fill_unit.sv
// Single-outstanding icache line fill: one memory request, out-of-order word collection,
// 16-beat icache write followed by a tag/metadata write and a completion pulse.
module icache_fill_unit #(
  parameter logic [2:0] REQ_ID = 3'b001
) (
  input logic         clk,
  input logic         reset,
  icache_fill_if.master bus
);
  localparam int unsigned WORDS  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LINE_W = 26;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q;
  logic [31:0]         buf_q [WORDS];
  logic [WORDS-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                resp_hit_c;
  logic [31:0]         line_addr_c;

  assign resp_hit_c  = bus.mem_resp_valid && (bus.mem_resp_id == REQ_ID);
  assign line_addr_c = {line_q, 6'b0};

  // Next state and state-decoded outputs; only miss_ready sees an input (reset).
  always_comb begin
    state_d              = state_q;
    mask_d               = mask_q;
    bus.miss_ready       = 1'b0;
    bus.mem_req_valid    = 1'b0;
    bus.mem_req_addr     = '0;
    bus.mem_req_id       = '0;
    bus.icache_enable    = 1'b0;
    bus.write_enable     = 1'b0;
    bus.VA_to_access     = '0;
    bus.write_data       = '0;
    bus.physical_tag     = '0;
    bus.tag_write_enable = 1'b0;
    bus.valid_data       = 1'b0;
    bus.dirty_data       = 1'b0;
    bus.fill_done        = 1'b0;
    bus.fill_addr        = '0;

    if (resp_hit_c && (state_q == WAIT || state_q == DRAIN)) begin
      mask_d = mask_q | (WORDS'(1) << bus.mem_resp_word);
    end

    unique case (state_q)
      IDLE: begin
        bus.miss_ready = !reset;
        if (bus.miss_valid) begin
          state_d = REQ;
          mask_d  = '0;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = line_addr_c;
        bus.mem_req_id    = REQ_ID;
        if (bus.mem_req_ready) begin
          state_d = bus.flush ? DRAIN : WAIT;
        end else if (bus.flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else if (&mask_d) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.icache_enable = 1'b1;
        bus.write_enable  = 1'b1;
        bus.VA_to_access  = {line_q, cnt_q, 2'b00};
        bus.write_data    = buf_q[cnt_q];
        bus.physical_tag  = line_q[LINE_W-1:2];
        if (cnt_q == CNT_W'(WORDS - 1)) begin
          bus.tag_write_enable = 1'b1;
          bus.valid_data       = 1'b1;
          state_d              = DONE;
        end
      end
      DONE: begin
        bus.fill_done = 1'b1;
        bus.fill_addr = line_addr_c;
        state_d       = IDLE;
      end
      DRAIN: begin
        if (&mask_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= (state_q == WRITE) ? cnt_q + CNT_W'(1) : '0;
      if (state_q == IDLE && bus.miss_valid) begin
        line_q <= bus.miss_addr[31:6];
      end
    end
  end

  // Line buffer is data only; it is never reset and only filled while collecting.
  always_ff @(posedge clk) begin
    if (resp_hit_c && state_q == WAIT) begin
      buf_q[bus.mem_resp_word] <= bus.mem_resp_data;
    end
  end
endmodule
